// File: rtl/sd_photo_pkg.sv
// Shared constants, types and BMP header helpers for the photo capture (SDRAM -> SD) path.
package sd_photo_pkg;

    localparam int unsigned BMP_HEAD_NUM = 54;
    localparam int unsigned SEC_BYTES    = 512;
    localparam int unsigned SEC_WORDS    = SEC_BYTES / 2;
    localparam int unsigned HDR_WORDS    = BMP_HEAD_NUM / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEC   = 2'd2,
        ST_DONE  = 2'd3
    } photo_state_e;

    typedef enum logic [1:0] {
        PH_BG = 2'd0,
        PH_RB = 2'd1,
        PH_GR = 2'd2
    } pack_phase_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic rgb888_t expand565(logic [15:0] px);
        rgb888_t c;
        c.r = {px[15:11], px[15:13]};
        c.g = {px[10:5],  px[10:9]};
        c.b = {px[4:0],   px[4:2]};
        return c;
    endfunction

    function automatic logic [31:0] file_bytes(logic [31:0] h, logic [31:0] v);
        return 32'(BMP_HEAD_NUM) + 32'd3 * h * v;
    endfunction

    function automatic logic [31:0] sec_num(logic [31:0] h, logic [31:0] v);
        return (file_bytes(h, v) + 32'(SEC_BYTES) - 32'd1) / 32'(SEC_BYTES);
    endfunction

    // Byte idx of the 54-byte BMP header; everything after "BM" is 32-bit little-endian
    // fields, with planes/bpp treated as one 32-bit word.
    function automatic logic [7:0] bmp_hdr_byte(logic [31:0] idx, logic [31:0] h, logic [31:0] v);
        logic [31:0] fld;
        logic [31:0] k;
        logic [1:0]  bsel;
        logic [7:0]  res;
        k    = (idx - 32'd2) >> 2;
        bsel = 2'(idx - 32'd2);
        case (k)
            32'd0:         fld = file_bytes(h, v);
            32'd2:         fld = 32'(BMP_HEAD_NUM);
            32'd3:         fld = 32'd40;
            32'd4:         fld = h;
            32'd5:         fld = v;
            32'd6:         fld = 32'h0018_0001;
            32'd8:         fld = 32'd3 * h * v;
            32'd9, 32'd10: fld = 32'd2835;
            default:       fld = 32'd0;
        endcase
        res = 8'(fld >> {bsel, 3'b000});
        if (idx == 32'd0) res = 8'h42;
        if (idx == 32'd1) res = 8'h4D;
        if (idx >= 32'(BMP_HEAD_NUM)) res = 8'h00;
        return res;
    endfunction

endpackage

// File: rtl/sd_write_photo_if.sv
// SDRAM read port and SD sector-write port seen by the photo writer.
interface sd_write_photo_if;

    logic        sdram_rd_load;
    logic        sdram_rd_en;
    logic [15:0] sdram_rd_data;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic        wr_busy;
    logic        wr_req;
    logic [15:0] wr_data;

    modport master (
        output sdram_rd_load, sdram_rd_en, wr_start_en, wr_sec_addr, wr_data,
        input  sdram_rd_data, wr_busy, wr_req
    );

    modport slave (
        input  sdram_rd_load, sdram_rd_en, wr_start_en, wr_sec_addr, wr_data,
        output sdram_rd_data, wr_busy, wr_req
    );

endinterface

// File: rtl/rgb565_bmp_packer.sv
// Packs RGB565 pixel pairs into three BGR888 file words and paces the SDRAM reads.
module rgb565_bmp_packer
    import sd_photo_pkg::*;
#(
    parameter int unsigned PIX_NUM = 307200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        prefetch_i,
    input  logic        adv_i,
    input  logic [15:0] rd_data_i,
    output logic        rd_en_o,
    output logic [15:0] word_c_o
);

    localparam int unsigned CW = $clog2(PIX_NUM + 1);

    pack_phase_e   phase_q;
    logic [15:0]   p0_q;
    logic [15:0]   p1_q;
    logic          rd_en_q;
    logic          rd_vld_q;
    logic          rd_sel_q;
    logic [CW-1:0] rd_cnt_q;
    rgb888_t       c0_c;
    rgb888_t       c1_c;

    assign rd_en_o = rd_en_q;

    // Current file word for the active phase of the pixel pair.
    always_comb begin
        c0_c     = expand565(p0_q);
        c1_c     = expand565(p1_q);
        word_c_o = 16'h0000;
        case (phase_q)
            PH_BG:   word_c_o = {c0_c.b, c0_c.g};
            PH_RB:   word_c_o = {c0_c.r, c1_c.b};
            PH_GR:   word_c_o = {c1_c.g, c1_c.r};
            default: word_c_o = 16'h0000;
        endcase
    end

    // rd_sel_q stays put for the 2-cycle read latency; wr_req spacing keeps issues further apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= PH_BG;
            p0_q     <= 16'h0000;
            p1_q     <= 16'h0000;
            rd_en_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rd_cnt_q <= '0;
        end else begin
            rd_en_q  <= 1'b0;
            rd_vld_q <= rd_en_q;
            if (rd_vld_q) begin
                if (rd_sel_q) p1_q <= rd_data_i;
                else          p0_q <= rd_data_i;
            end
            if (clear_i) begin
                phase_q  <= PH_BG;
                rd_cnt_q <= '0;
            end else if (prefetch_i) begin
                rd_en_q  <= 1'b1;
                rd_sel_q <= 1'b0;
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end else if (adv_i) begin
                case (phase_q)
                    PH_BG: begin
                        phase_q  <= PH_RB;
                        rd_en_q  <= 1'b1;
                        rd_sel_q <= 1'b1;
                        rd_cnt_q <= rd_cnt_q + CW'(1);
                    end
                    PH_RB: phase_q <= PH_GR;
                    default: begin
                        phase_q <= PH_BG;
                        if (rd_cnt_q < CW'(PIX_NUM)) begin
                            rd_en_q  <= 1'b1;
                            rd_sel_q <= 1'b0;
                            rd_cnt_q <= rd_cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sd_write_photo.sv
// Streams one SDRAM RGB565 frame as a 24-bit BMP file into consecutive SD sectors.
module sd_write_photo
    import sd_photo_pkg::*;
#(
    parameter logic [31:0] PHOTO_SECTION_ADDR = 32'd16448,
    parameter int unsigned H_PIXEL            = 640,
    parameter int unsigned V_PIXEL            = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_start,
    output logic              busy,
    output logic              done,
    sd_write_photo_if.master  sd_if
);

    localparam int unsigned PIX_NUM   = H_PIXEL * V_PIXEL;
    localparam int unsigned PIX_WORDS = 3 * PIX_NUM / 2;
    localparam int unsigned PIX_END   = HDR_WORDS + PIX_WORDS;
    localparam int unsigned SEC_NUM   = sec_num(H_PIXEL, V_PIXEL);
    localparam int unsigned TOT_WORDS = SEC_NUM * SEC_WORDS;
    localparam int unsigned WCW       = $clog2(TOT_WORDS + 1);
    localparam int unsigned SCW       = $clog2(SEC_NUM + 1);

    photo_state_e   state_q;
    logic           busy_q;
    logic           done_q;
    logic           load_q;
    logic           start_en_q;
    logic [31:0]    sec_addr_q;
    logic [SCW-1:0] sec_cnt_q;
    logic [WCW-1:0] word_cnt_q;
    logic [15:0]    wr_data_q;
    logic           wr_busy_d0_q;
    logic           wr_busy_d1_q;

    logic           busy_neg_c;
    logic           req_c;
    logic           pix_region_c;
    logic           pack_clear_c;
    logic           pack_prefetch_c;
    logic           pack_adv_c;
    logic           pack_rd_en;
    logic [15:0]    pack_word_c;
    logic [31:0]    hdr_idx_c;
    logic [15:0]    word_sel_c;

    assign sd_if.sdram_rd_load = load_q;
    assign sd_if.sdram_rd_en   = pack_rd_en;
    assign sd_if.wr_start_en   = start_en_q;
    assign sd_if.wr_sec_addr   = sec_addr_q;
    assign sd_if.wr_data       = wr_data_q;
    assign busy                = busy_q;
    assign done                = done_q;

    // Sector-finished detect and packer controls.
    always_comb begin
        busy_neg_c      = wr_busy_d1_q & ~wr_busy_d0_q;
        req_c           = (state_q == ST_SEC) && sd_if.wr_req;
        pix_region_c    = (word_cnt_q >= WCW'(HDR_WORDS)) && (word_cnt_q < WCW'(PIX_END));
        pack_clear_c    = (state_q == ST_IDLE) && capture_start;
        pack_prefetch_c = (state_q == ST_START) && (sec_cnt_q == '0);
        pack_adv_c      = req_c && pix_region_c;
    end

    // File word for the current word count: header, pixel data, then sector padding.
    always_comb begin
        hdr_idx_c  = 32'(word_cnt_q) << 1;
        word_sel_c = 16'h0000;
        if (word_cnt_q < WCW'(HDR_WORDS)) begin
            word_sel_c = {bmp_hdr_byte(hdr_idx_c, H_PIXEL, V_PIXEL),
                          bmp_hdr_byte(hdr_idx_c + 32'd1, H_PIXEL, V_PIXEL)};
        end else if (pix_region_c) begin
            word_sel_c = pack_word_c;
        end
    end

    rgb565_bmp_packer #(
        .PIX_NUM (PIX_NUM)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (pack_clear_c),
        .prefetch_i (pack_prefetch_c),
        .adv_i      (pack_adv_c),
        .rd_data_i  (sd_if.sdram_rd_data),
        .rd_en_o    (pack_rd_en),
        .word_c_o   (pack_word_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_q       <= 1'b0;
            start_en_q   <= 1'b0;
            sec_addr_q   <= 32'd0;
            sec_cnt_q    <= '0;
            word_cnt_q   <= '0;
            wr_data_q    <= 16'h0000;
            wr_busy_d0_q <= 1'b0;
            wr_busy_d1_q <= 1'b0;
        end else begin
            wr_busy_d0_q <= sd_if.wr_busy;
            wr_busy_d1_q <= wr_busy_d0_q;
            load_q       <= 1'b0;
            start_en_q   <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (capture_start) begin
                        state_q    <= ST_START;
                        busy_q     <= 1'b1;
                        load_q     <= 1'b1;
                        sec_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        sec_addr_q <= PHOTO_SECTION_ADDR;
                    end
                end
                ST_START: begin
                    start_en_q <= 1'b1;
                    state_q    <= ST_SEC;
                end
                ST_SEC: begin
                    if (req_c) begin
                        wr_data_q  <= word_sel_c;
                        word_cnt_q <= word_cnt_q + WCW'(1);
                    end
                    if (busy_neg_c) begin
                        sec_cnt_q  <= sec_cnt_q + SCW'(1);
                        sec_addr_q <= sec_addr_q + 32'd1;
                        if (sec_cnt_q == SCW'(SEC_NUM - 1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_START;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_write_photo.sv
// Bench for sd_write_photo: SD sector controller and SDRAM models, file-image reference model.
module tb_sd_write_photo;

    localparam int unsigned H          = 32;
    localparam int unsigned V          = 16;
    localparam logic [31:0] BASE       = 32'd16448;
    localparam int unsigned PIXN       = H * V;
    localparam int unsigned FILE_BYTES = 54 + 3 * PIXN;
    localparam int unsigned NSEC       = 4;
    localparam int unsigned NWORDS     = NSEC * 256;
    localparam int          GAP        = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_start = 1'b0;
    logic busy;
    logic done;

    sd_write_photo_if sif ();

    sd_write_photo #(
        .PHOTO_SECTION_ADDR (BASE),
        .H_PIXEL            (H),
        .V_PIXEL            (V)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_start (capture_start),
        .busy          (busy),
        .done          (done),
        .sd_if         (sif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] fb [0:2*NWORDS-1];

    int widx = 0;
    int n_start = 0;
    int n_rd = 0;
    int n_done = 0;
    int n_load = 0;
    logic [15:0] first_word = 16'h0;
    logic [31:0] first_addr = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(int unsigned a);
        case (a)
            0: return 16'hF800;
            1: return 16'h07E0;
            2: return 16'h001F;
            3: return 16'hFFFF;
            default: return 16'((a * 32'd40503) ^ (a << 3));
        endcase
    endfunction

    function automatic logic [15:0] exp_word(int k);
        return {fb[2*k], fb[2*k+1]};
    endfunction

    task automatic put32(input int at, input logic [31:0] val);
        for (int i = 0; i < 4; i++) fb[at+i] = 8'(val >> (8 * i));
    endtask

    // Expected BMP byte image: header fields, bottom-up BGR888 pixels, zero padding.
    task automatic build_model();
        logic [15:0] px;
        for (int i = 0; i < 2 * NWORDS; i++) fb[i] = 8'h00;
        fb[0] = 8'h42;
        fb[1] = 8'h4D;
        put32(2, FILE_BYTES);
        put32(10, 54);
        put32(14, 40);
        put32(18, H);
        put32(22, V);
        fb[26] = 8'd1;
        fb[28] = 8'd24;
        put32(34, 3 * PIXN);
        put32(38, 2835);
        put32(42, 2835);
        for (int i = 0; i < int'(PIXN); i++) begin
            px = pix(i);
            fb[54 + 3*i]     = {px[4:0], px[4:2]};
            fb[54 + 3*i + 1] = {px[10:5], px[10:9]};
            fb[54 + 3*i + 2] = {px[15:11], px[15:13]};
        end
    endtask

    // SDRAM model: data appears one cycle after the read enable.
    initial begin
        int ptr = 0;
        bit pend = 1'b0;
        sif.sdram_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (pend) begin
                sif.sdram_rd_data = pix(ptr);
                ptr++;
            end
            if (sif.sdram_rd_load) ptr = 0;
            pend = sif.sdram_rd_en;
        end
    end

    // Compare process: every accepted word against the reference image, every sector address.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sif.sdram_rd_load) begin
                widx = 0; n_start = 0; n_rd = 0; n_done = 0; n_load++;
            end
            if (sif.wr_start_en) begin
                chk($sformatf("sec_addr%0d", n_start), sif.wr_sec_addr, BASE + 32'(n_start));
                if (n_start == 0) first_addr = sif.wr_sec_addr;
                n_start++;
            end
            if (sif.sdram_rd_en) n_rd++;
            if (done) n_done++;
            if (sif.wr_req && rst_n) begin
                if (widx < int'(NWORDS)) chk($sformatf("word%0d", widx), 32'(sif.wr_data), 32'(exp_word(widx)));
                else chk("word_idx_range", widx, NWORDS - 1);
                if (widx == 0) first_word = sif.wr_data;
                widx++;
            end
        end
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sif.wr_start_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_start_en_seen", 32'(ok), 1);
    endtask

    task automatic do_reset();
        sif.wr_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pulses", {29'd0, sif.sdram_rd_load, sif.sdram_rd_en, sif.wr_start_en}, 0);
        chk("rst_addr", sif.wr_sec_addr, 0);
        chk("rst_data", 32'(sif.wr_data), 0);
        rst_n = 1'b1;
        sif.wr_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_idle", {30'd0, busy, sif.wr_start_en}, 0);
    endtask

    task automatic do_frame(input int abort_sec, input bit repulse, input bit stall);
        bit ok;
        int lag;
        int g;
        @(negedge clk);
        capture_start = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        for (int s = 0; s < int'(NSEC); s++) begin
            wait_start(ok);
            if (!ok) return;
            repeat (3) @(negedge clk);
            sif.wr_busy = 1'b1;
            for (int k = 0; k < 256; k++) begin
                g = (stall && s == 0 && k >= 40 && k < 44) ? 100 : GAP;
                repeat (g - 1) @(negedge clk);
                if (s == abort_sec && k == 50) begin
                    do_reset();
                    return;
                end
                if (repulse && s == 1 && k == 10) capture_start = 1'b1;
                sif.wr_req = 1'b1;
                @(negedge clk);
                sif.wr_req = 1'b0;
                capture_start = 1'b0;
            end
            repeat (10) @(negedge clk);
            sif.wr_busy = 1'b0;
        end
        lag = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                lag = i;
                break;
            end
        end
        chk("done_in_window", 32'(lag >= 1 && lag <= 3), 1);
        capture_start = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk("rd_en_pulses", n_rd, PIXN);
        chk("start_pulses", n_start, NSEC);
        chk("words_taken", widx, NWORDS);
        chk("done_pulses", n_done, 1);
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.wr_busy = 1'b0;
        sif.wr_req  = 1'b0;
        build_model();
        chk("model_w0", 32'(exp_word(0)), 32'h424D);
        chk("model_w1", 32'(exp_word(1)), 32'h3606);
        chk("model_w17", 32'(exp_word(17)), 32'h0006);
        chk("model_w19", 32'(exp_word(19)), 32'h130B);
        chk("model_w27", 32'(exp_word(27)), 32'h0000);
        chk("model_w28", 32'(exp_word(28)), 32'hFF00);
        chk("model_w29", 32'(exp_word(29)), 32'hFF00);
        chk("model_w30", 32'(exp_word(30)), 32'hFF00);
        chk("model_w31", 32'(exp_word(31)), 32'h00FF);
        chk("model_w795", 32'(exp_word(795)), 32'h0000);

        repeat (3) @(negedge clk);
        chk("reset_state", {27'd0, busy, done, sif.sdram_rd_load, sif.sdram_rd_en, sif.wr_start_en}, 0);
        chk("reset_data", {sif.wr_sec_addr[15:0], sif.wr_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_frame(-1, 1'b1, 1'b1);
        chk("f1_first_word", 32'(first_word), 32'h424D);
        do_frame(-1, 1'b0, 1'b0);
        do_frame(2, 1'b0, 1'b0);
        first_word = 16'h0;
        first_addr = 32'h0;
        do_frame(-1, 1'b0, 1'b0);
        chk("restart_word", 32'(first_word), 32'h424D);
        chk("restart_addr", first_addr, 32'd16448);
        chk("load_pulses", n_load, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
